// File: rtl/uart_bus_master_pkg.sv
// uart_bus_pkg: shared definitions for the UART bus master slice.
//   - one-hot state indices and the state enum (IDLE/WR/RD/TURN)
//   - default data width
//   - timeout_enabled(): TIMEOUT==0 means a pending read waits forever
package uart_bus_pkg;

    localparam int DATA_W_DEF = 8;

    // Bit positions of the one-hot state register.
    localparam int IDX_IDLE = 0;
    localparam int IDX_WR   = 1;
    localparam int IDX_RD   = 2;
    localparam int IDX_TURN = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_WR   = 4'b0010,
        ST_RD   = 4'b0100,
        ST_TURN = 4'b1000
    } state_t;

    // A zero TIMEOUT disables the read-wait abort entirely.
    function automatic logic timeout_enabled(input int timeout);
        return (timeout != 0);
    endfunction

endpackage

// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: host-side handshake between CPU/glue logic and the
// UART bus master.
//   wr_valid/wr_data/wr_ready : byte push handshake
//   rd_req/rd_busy            : read request pulse and pending indication
//   rd_valid/rd_data/rd_auto  : read completion pulse, byte, auto-read flag
//   rd_timeout                : pending read aborted
// Modport master = host side, slave = the bus master block.
interface uart_bus_master_if #(
    parameter int DATA_W = 8
) ();

    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              rd_req;
    logic              rd_busy;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_timeout;
    logic              rd_auto;

    modport master (
        output wr_valid, wr_data, rd_req,
        input  wr_ready, rd_busy, rd_valid, rd_data, rd_timeout, rd_auto
    );

    modport slave (
        input  wr_valid, wr_data, rd_req,
        output wr_ready, rd_busy, rd_valid, rd_data, rd_timeout, rd_auto
    );

endinterface

// File: rtl/uart_bus_master_rd_timer.sv
// uart_rd_timer: read-wait timeout counter.
//   clk, rst : clock, asynchronous active-low reset
//   clr      : hold the count at zero
//   en       : count this cycle (read pending, RX FIFO empty)
//   term     : asserted on the last allowed wait cycle (never when TIMEOUT==0)
module uart_rd_timer
    import uart_bus_pkg::*;
#(
    parameter int CNT_W   = 11,
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Terminal detect; suppressed entirely when the timeout is disabled.
    always_comb begin
        if (timeout_enabled(TIMEOUT)) begin
            term = en && (cnt_r == LAST_CNT);
        end else begin
            term = 1'b0;
        end
    end

    // Wait counter; restarts after a terminal cycle so it never needs a wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || term) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// uart_bus_master: host-side initiator for the UART chip-select bus.
//   clk, rst          : clock, asynchronous active-low reset
//   host              : host handshake (uart_bus_master_if.slave)
//   cs, we, oe        : UART strobes, decoded from the one-hot state
//   data              : shared tristate byte bus, driven only while we=1
//   tx_full, rx_empty : UART FIFO flags used for flow control
// Optional macro UART_BUS_MASTER_AUTORX_EN: drain the RX FIFO autonomously
// while idle, flagging such completions with rd_auto.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 11
) (
    input  logic              clk,
    input  logic              rst,
    uart_bus_master_if.slave  host,
    output logic              cs,
    output logic              we,
    output logic              oe,
    inout  wire  [DATA_W-1:0] data,
    input  logic              tx_full,
    input  logic              rx_empty
);

    state_t            state_r, state_s;
    logic              pend_r, pend_s;
    logic              auto_r, auto_s;
    logic              busy_r;
    logic              run_r;
    logic [DATA_W-1:0] wr_byte_r;
    logic [DATA_W-1:0] rd_data_r;
    logic              rd_valid_r;
    logic              rd_auto_r;
    logic              rd_timeout_r;
    logic              wr_ready_s;
    logic              wr_hs_s;
    logic              rd_acc_s;
    logic              tmr_en_s;
    logic              tmr_term_s;

    // run_r keeps wr_ready low until the first clock after reset release.
    // A serviceable pending read blocks writes so it wins the bus.
    assign wr_ready_s = (state_r == ST_IDLE) && run_r && !tx_full && !(pend_r && !rx_empty);
    assign wr_hs_s    = wr_ready_s && host.wr_valid;
    assign rd_acc_s   = host.rd_req && !busy_r;

    assign cs   = state_r[IDX_WR] | state_r[IDX_RD];
    assign we   = state_r[IDX_WR];
    assign oe   = state_r[IDX_RD];
    assign data = state_r[IDX_WR] ? wr_byte_r : {DATA_W{1'bz}};

    assign host.wr_ready   = wr_ready_s;
    assign host.rd_busy    = busy_r;
    assign host.rd_valid   = rd_valid_r;
    assign host.rd_data    = rd_data_r;
    assign host.rd_timeout = rd_timeout_r;
    assign host.rd_auto    = rd_auto_r;

    uart_rd_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_rd_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (!pend_r),
        .en   (tmr_en_s),
        .term (tmr_term_s)
    );

    // Next-state, pending-read and auto-read bookkeeping.
    always_comb begin
        state_s  = state_r;
        pend_s   = pend_r;
        auto_s   = auto_r;
        tmr_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A request arriving this cycle is not yet in pend_r, so a
                // simultaneous write goes first and the read follows.
                if (pend_r && !rx_empty) begin
                    state_s = ST_RD;
                end else if (wr_hs_s) begin
                    state_s = ST_WR;
                end else if (rd_acc_s && !rx_empty) begin
                    state_s = ST_RD;
`ifdef UART_BUS_MASTER_AUTORX_EN
                end else if (!pend_r && !rd_acc_s && !rx_empty && run_r) begin
                    state_s = ST_RD;
                    auto_s  = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
                tmr_en_s = pend_r && rx_empty;
                if (tmr_term_s) begin
                    pend_s = 1'b0;
                end else begin
                    pend_s = pend_r;
                end
            end
            ST_WR: begin
                state_s = ST_IDLE;
            end
            ST_RD: begin
                state_s = ST_TURN;
                pend_s  = 1'b0;
            end
            ST_TURN: begin
                state_s = ST_IDLE;
                auto_s  = 1'b0;
            end
            default: begin
                state_s = ST_IDLE;
                pend_s  = 1'b0;
                auto_s  = 1'b0;
            end
        endcase
        // Acceptance needs busy_r=0, which never coincides with RD.
        if (rd_acc_s) begin
            pend_s = 1'b1;
        end else begin
            pend_s = pend_s;
        end
    end

    // State, handshake latches and registered host outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            pend_r       <= 1'b0;
            auto_r       <= 1'b0;
            busy_r       <= 1'b0;
            run_r        <= 1'b0;
            wr_byte_r    <= {DATA_W{1'b0}};
            rd_data_r    <= {DATA_W{1'b0}};
            rd_valid_r   <= 1'b0;
            rd_auto_r    <= 1'b0;
            rd_timeout_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            pend_r       <= pend_s;
            auto_r       <= auto_s;
            busy_r       <= pend_s | auto_s;
            run_r        <= 1'b1;
            if (wr_hs_s) begin
                wr_byte_r <= host.wr_data;
            end
            if (state_r == ST_RD) begin
                rd_data_r <= data;
            end
            // Completion pulses line up with the TURN cycle.
            rd_valid_r   <= (state_r == ST_RD);
            rd_auto_r    <= (state_r == ST_RD) && auto_r;
            rd_timeout_r <= tmr_term_s;
        end
    end

endmodule
